// File: rtl/pipelined_mac.sv
// ---------------------------------------------------------------------------
// pipelined_mac
//   Pipelined multiply-accumulate engine. Operand pairs (a, b) arrive on a
//   valid/ready stream and are multiplied. The products are summed into a
//   wide accumulator. The pair flagged 'last' closes the vector, and the
//   vector's dot product is presented on an output valid/ready channel.
//   On overflow the accumulator either wraps or saturates, depending on
//   the SATURATE parameter.
//
//   Pipeline (all stages hold while the output is stalled):
//     S1  operand capture (a, b, last, valid)
//     S2  full-width product
//     S3  accumulate; a 'last' entry loads the output register
//
// Parameters
//   DATA_W    operand width
//   ACC_W     accumulator/result width (>= 2*DATA_W)
//   SIGNED    0: unsigned, 1: two's-complement operands and accumulator
//   SATURATE  0: wrap modulo 2^ACC_W, 1: clamp at the range limits
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand pair valid
//   in_ready   engine accepts a pair this cycle
//   in_a       multiplicand
//   in_b       multiplier
//   in_last    pair is the final element of its vector
//   out_valid  acc_out holds a completed dot product
//   out_ready  consumer takes acc_out this cycle
//   acc_out    completed dot product
//   ovf        overflow occurred somewhere in the vector on acc_out
// ---------------------------------------------------------------------------
module pipelined_mac #(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 2*DATA_W+8,
  parameter bit SIGNED   = 1'b0,
  parameter bit SATURATE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              ovf
);

  localparam int PROD_W = 2*DATA_W;

  // The product must fit in the accumulator, or the first element of a
  // vector could already be wrong.
  if (ACC_W < PROD_W) begin : g_cfg_check
    $error("pipelined_mac: ACC_W (%0d) must be >= 2*DATA_W (%0d)", ACC_W, PROD_W);
  end

  // A held result freezes the whole pipeline. No pair is accepted then.
  logic stall;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // ---------------- S1: operand capture ----------------
  logic              s1_valid_reg;
  logic              s1_last_reg;
  logic [DATA_W-1:0] s1_a_reg;
  logic [DATA_W-1:0] s1_b_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_last_reg  <= 1'b0;
      s1_a_reg     <= '0;
      s1_b_reg     <= '0;
    end else if (!stall) begin
      // in_ready is 1 whenever we get here, so in_valid alone is the transfer.
      s1_valid_reg <= in_valid;
      s1_last_reg  <= in_last;
      s1_a_reg     <= in_a;
      s1_b_reg     <= in_b;
    end
  end

  // ---------------- S2: product ----------------
  // Both operands are extended to the full product width first. The low
  // PROD_W bits of an unsigned multiply of the extended values are then the
  // correct product in either signedness.
  logic [PROD_W-1:0] a_ext;
  logic [PROD_W-1:0] b_ext;
  logic [PROD_W-1:0] prod_next;

  assign a_ext     = {{DATA_W{SIGNED && s1_a_reg[DATA_W-1]}}, s1_a_reg};
  assign b_ext     = {{DATA_W{SIGNED && s1_b_reg[DATA_W-1]}}, s1_b_reg};
  assign prod_next = a_ext * b_ext;

  logic              s2_valid_reg;
  logic              s2_last_reg;
  logic [PROD_W-1:0] s2_prod_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_reg <= 1'b0;
      s2_last_reg  <= 1'b0;
      s2_prod_reg  <= '0;
    end else if (!stall) begin
      s2_valid_reg <= s1_valid_reg;
      s2_last_reg  <= s1_last_reg;
      s2_prod_reg  <= prod_next;
    end
  end

  // ---------------- S3: accumulate ----------------
  logic             first_reg;   // next valid S3 entry starts a new vector
  logic [ACC_W-1:0] acc_reg;
  logic             sticky_reg;

  // The sum is formed one bit wider than the accumulator. The extra bit
  // shows the carry-out (unsigned) or the true sign (signed).
  logic [ACC_W:0]   prod_wide;
  logic [ACC_W:0]   base_wide;
  logic [ACC_W:0]   sum_wide;
  logic             ovf_now;
  logic [ACC_W-1:0] sum_next;
  logic             sticky_next;

  assign prod_wide = {{(ACC_W+1-PROD_W){SIGNED && s2_prod_reg[PROD_W-1]}}, s2_prod_reg};
  assign base_wide = first_reg ? '0 : {SIGNED && acc_reg[ACC_W-1], acc_reg};
  assign sum_wide  = base_wide + prod_wide;

  // Signed overflow: the result does not fit in ACC_W signed bits, so the
  // top two bits of the widened sum disagree.
  assign ovf_now = SIGNED ? (sum_wide[ACC_W] ^ sum_wide[ACC_W-1]) : sum_wide[ACC_W];

  always_comb begin
    sum_next = sum_wide[ACC_W-1:0];
    if (ovf_now && SATURATE) begin
      if (!SIGNED)
        sum_next = '1;
      else if (sum_wide[ACC_W])
        sum_next = {1'b1, {(ACC_W-1){1'b0}}};   // most negative
      else
        sum_next = {1'b0, {(ACC_W-1){1'b1}}};   // most positive
    end
  end

  // The first entry of a vector discards the previous vector's flag.
  assign sticky_next = (sticky_reg && !first_reg) || ovf_now;

  always_ff @(posedge clk) begin
    if (rst) begin
      first_reg  <= 1'b1;
      acc_reg    <= '0;
      sticky_reg <= 1'b0;
      out_valid  <= 1'b0;
      acc_out    <= '0;
      ovf        <= 1'b0;
    end else if (!stall) begin
      if (s2_valid_reg) begin
        acc_reg    <= sum_next;
        sticky_reg <= sticky_next;
        first_reg  <= s2_last_reg;
      end
      // Without a stall, any held result is being accepted this cycle. So
      // out_valid follows whether a new result is arriving, which also
      // covers back-to-back results.
      out_valid <= s2_valid_reg && s2_last_reg;
      if (s2_valid_reg && s2_last_reg) begin
        acc_out <= sum_next;
        ovf     <= sticky_next;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_mac.sv
// ---------------------------------------------------------------------------
// tb_pipelined_mac
//   Five engine configurations share one operand stream and one out_ready.
//   Handshake timing does not depend on the data, so all five instances
//   stall identically. A driver pushes the expected result of each vector
//   into a queue per configuration. A negedge monitor pops and compares
//   every accepted result.
// ---------------------------------------------------------------------------
module tb_pipelined_mac;

  localparam int NCFG = 5;
  localparam int DW   = 8;

  // cfg0: U24 sat, cfg1: U16 sat, cfg2: U16 wrap, cfg3: S16 sat, cfg4: S16 wrap
  function automatic int cfg_acc_w(input int i);
    return (i == 0) ? 24 : 16;
  endfunction
  function automatic bit cfg_signed(input int i);
    return i >= 3;
  endfunction
  function automatic bit cfg_sat(input int i);
    return (i == 0) || (i == 1) || (i == 3);
  endfunction

  typedef struct packed {
    logic [63:0] acc;
    logic        ovf;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_a = '0;
  logic [DW-1:0] in_b = '0;
  logic          in_last = 1'b0;
  logic          out_ready;
  logic          in_ready_w  [NCFG];
  logic          out_valid_w [NCFG];
  logic          ovf_w       [NCFG];
  logic [23:0]   acc_w       [NCFG];

  bit            rand_mode = 1'b0;
  bit            forced_ready = 1'b1;
  int            checks = 0;
  int            failures = 0;

  exp_t          exp_q [NCFG][$];
  logic [7:0]    vec_a [$];
  logic [7:0]    vec_b [$];
  logic [23:0]   last_acc [NCFG];
  logic          last_ovf [NCFG];

  genvar gi;
  for (gi = 0; gi < NCFG; gi++) begin : g_dut
    localparam int AW = cfg_acc_w(gi);
    logic [AW-1:0] acc_o;
    pipelined_mac #(
      .DATA_W(DW), .ACC_W(AW), .SIGNED(cfg_signed(gi)), .SATURATE(cfg_sat(gi))
    ) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready_w[gi]),
      .in_a(in_a), .in_b(in_b), .in_last(in_last),
      .out_valid(out_valid_w[gi]), .out_ready(out_ready),
      .acc_out(acc_o), .ovf(ovf_w[gi])
    );
    assign acc_w[gi] = 24'(acc_o);
  end

  initial forever #5 clk = ~clk;

  // Sole driver of out_ready.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_mode ? ($urandom_range(0, 3) != 0) : forced_ready;
    end
  end

  // Reference: dot product with a range check after each addition.
  function automatic exp_t model(input int cfg);
    int     aw   = cfg_acc_w(cfg);
    bit     sg   = cfg_signed(cfg);
    bit     sat  = cfg_sat(cfg);
    longint span = longint'(1) <<< aw;
    longint hi   = sg ? span / 2 - 1 : span - 1;
    longint lo   = sg ? -(span / 2) : 0;
    longint sum  = 0;
    bit     ov   = 1'b0;
    exp_t   e;
    foreach (vec_a[k]) begin
      longint av = sg ? longint'($signed(vec_a[k])) : longint'(vec_a[k]);
      longint bv = sg ? longint'($signed(vec_b[k])) : longint'(vec_b[k]);
      sum = sum + av * bv;
      if (sum > hi || sum < lo) begin
        ov = 1'b1;
        if (sat) begin
          sum = (sum > hi) ? hi : lo;
        end else begin
          sum = sum % span;
          if (sum < 0) sum = sum + span;
          if (sg && sum > hi) sum = sum - span;
        end
      end
    end
    e.acc = 64'(sum) & 64'(span - 1);
    e.ovf = ov;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  // Offers one pair and returns 1 time unit after the edge that takes it.
  task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input bit last);
    int n = 0;
    bit hs;
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
    forever begin
      @(negedge clk);
      hs = in_ready_w[0];
      @(posedge clk);
      if (hs) break;
      n++;
      if (n > 200) begin
        checks++; failures++;
        $display("FAIL handshake_timeout: pair (%0d,%0d) waited %0d cycles, limit 200", a, b, n);
        break;
      end
    end
    vec_a.push_back(a);
    vec_b.push_back(b);
    if (last) begin
      for (int i = 0; i < NCFG; i++) exp_q[i].push_back(model(i));
      vec_a.delete();
      vec_b.delete();
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    int pending;
    forever begin
      pending = 0;
      for (int i = 0; i < NCFG; i++) pending += exp_q[i].size();
      if (pending == 0 || n >= 1000) break;
      @(posedge clk);
      n++;
    end
    chk("drain_pending", 64'(pending), 64'd0);
    idle(3);
  endtask

  // Scoreboard monitor: compares each result on the cycle it is accepted.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int i = 0; i < NCFG; i++) begin
          if (out_valid_w[i] && out_ready) begin
            checks++;
            if (exp_q[i].size() == 0) begin
              failures++;
              $display("FAIL sb_unexpected cfg%0d: got acc=%0d ovf=%0d, required no result",
                       i, acc_w[i], ovf_w[i]);
            end else begin
              e = exp_q[i].pop_front();
              if (acc_w[i] !== e.acc[23:0] || ovf_w[i] !== e.ovf) begin
                failures++;
                $display("FAIL sb_result cfg%0d: got acc=%0d ovf=%0d, required acc=%0d ovf=%0d",
                         i, acc_w[i], ovf_w[i], e.acc[23:0], e.ovf);
              end
            end
            last_acc[i] = acc_w[i];
            last_ovf[i] = ovf_w[i];
          end
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra, rb;
    int len;
    int n;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid_w[0]), 64'd0);
    chk("reset_in_ready",  64'(in_ready_w[0]),  64'd1);
    chk("reset_acc_out",   64'(acc_w[0]),       64'd0);
    chk("reset_ovf",       64'(ovf_w[0]),       64'd0);
    idle(1);

    // Basic dot product and latency. The last pair is taken at edge E.
    // Expect out_valid low after E and E+1, high after E+2, low after E+3.
    send_pair(8'd3, 8'd4, 1'b0);
    send_pair(8'd5, 8'd6, 1'b0);
    send_pair(8'd7, 8'd8, 1'b1);
    @(negedge clk); chk("lat_e0", 64'(out_valid_w[0]), 64'd0);
    @(negedge clk); chk("lat_e1", 64'(out_valid_w[0]), 64'd0);
    @(negedge clk); chk("lat_e2", 64'(out_valid_w[0]), 64'd1);
    @(negedge clk); chk("lat_e3", 64'(out_valid_w[0]), 64'd0);
    drain();
    chk("dot98_acc", 64'(last_acc[0]), 64'd98);
    chk("dot98_ovf", 64'(last_ovf[0]), 64'd0);

    // Unsigned overflow: saturate vs wrap.
    send_pair(8'd255, 8'd255, 1'b0);
    send_pair(8'd255, 8'd255, 1'b1);
    drain();
    chk("u16_sat_acc",  64'(last_acc[1]), 64'd65535);
    chk("u16_sat_ovf",  64'(last_ovf[1]), 64'd1);
    chk("u16_wrap_acc", 64'(last_acc[2]), 64'd64514);
    chk("u16_wrap_ovf", 64'(last_ovf[2]), 64'd1);

    // Signed: (-128,-128),(-1,127).
    send_pair(8'h80, 8'h80, 1'b0);
    send_pair(8'hFF, 8'h7F, 1'b1);
    drain();
    chk("s16_dot_acc", 64'(last_acc[3]), 64'd16257);
    chk("s16_dot_ovf", 64'(last_ovf[3]), 64'd0);

    // Signed underflow: four (-128,127), true sum -65024.
    for (int k = 0; k < 4; k++) send_pair(8'h80, 8'h7F, k == 3);
    drain();
    chk("s16_sat_acc",  64'(last_acc[3]), 64'h8000);
    chk("s16_sat_ovf",  64'(last_ovf[3]), 64'd1);
    chk("s16_wrap_acc", 64'(last_acc[4]), 64'd512);
    chk("s16_wrap_ovf", 64'(last_ovf[4]), 64'd1);

    // Backpressure: the first result is held while later pairs queue behind it.
    forced_ready = 1'b0;
    idle(2);
    fork
      begin
        send_pair(8'd1, 8'd1, 1'b1);
        send_pair(8'd2, 8'd2, 1'b0);
        send_pair(8'd3, 8'd3, 1'b1);
      end
      begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!out_valid_w[0] && n < 20);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
          chk("bp_out_valid", 64'(out_valid_w[0]), 64'd1);
          chk("bp_hold_acc",  64'(acc_w[0]),       64'd1);
          chk("bp_in_ready",  64'(in_ready_w[0]),  64'd0);
          @(negedge clk);
        end
        forced_ready = 1'b1;
      end
    join
    drain();
    chk("bp_next_acc", 64'(last_acc[0]), 64'd13);
    chk("bp_next_ovf", 64'(last_ovf[0]), 64'd0);

    // Reset mid-vector discards the partial sum and the in-flight pair.
    send_pair(8'd9, 8'd9, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    vec_a.delete();
    vec_b.delete();
    @(negedge clk);
    chk("mid_rst_out_valid", 64'(out_valid_w[0]), 64'd0);
    chk("mid_rst_in_ready",  64'(in_ready_w[0]),  64'd1);
    chk("mid_rst_acc_out",   64'(acc_w[0]),       64'd0);
    chk("mid_rst_ovf",       64'(ovf_w[0]),       64'd0);
    idle(1);
    send_pair(8'd2, 8'd3, 1'b1);
    drain();
    chk("post_rst_acc", 64'(last_acc[0]), 64'd6);

    // Random vectors, random gaps, random out_ready.
    rand_mode = 1'b1;
    for (int v = 0; v < 1000; v++) begin
      len = $urandom_range(1, 16);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        case ($urandom_range(0, 5))
          0:       ra = 8'hFF;
          1:       ra = 8'h80;
          2:       ra = 8'h7F;
          default: ra = 8'($urandom);
        endcase
        rb = ($urandom_range(0, 4) == 0) ? 8'hFF : 8'($urandom);
        send_pair(ra, rb, k == len - 1);
      end
    end
    rand_mode = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
